fib_sequencer: RTL and testbench

FIB_SEQUENCER -- requirements
Module: fib_sequencer

---
 rtl/fib_sequencer_pkg.sv | 51 +++++
 rtl/fib_sequencer.sv | 142 ++++++++++++++
 tb/tb_fib_sequencer.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/fib_sequencer_pkg.sv
// rtl/fib_sequencer_pkg.sv - shared instruction-set constants and FSM states for fib_sequencer
package fib_sequencer_pkg;

    // Instruction word layouts:
    //   immediate form : {opcode[3:0], rd[3:0], imm[7:0]}
    //   register form  : {class[3:0],  rd[3:0], alu_op[3:0], rs[3:0]}
    localparam logic [3:0]  OPC_MOVI     = 4'h1;
    localparam logic [3:0]  CLS_REGISTER = 4'h2;
    localparam logic [3:0]  ALU_MOV      = 4'h0;
    localparam logic [3:0]  ALU_ADD      = 4'h1;
    localparam logic [15:0] INSTR_NOP    = 16'h0000;

    localparam logic [3:0] R0  = 4'd0,  R1  = 4'd1,  R2  = 4'd2,  R3  = 4'd3;
    localparam logic [3:0] R4  = 4'd4,  R5  = 4'd5,  R6  = 4'd6,  R7  = 4'd7;
    localparam logic [3:0] R8  = 4'd8,  R9  = 4'd9,  R10 = 4'd10, R11 = 4'd11;
    localparam logic [3:0] R12 = 4'd12, R13 = 4'd13, R14 = 4'd14, R15 = 4'd15;

    // Bit position of carry within the decoder's flags vector
    localparam int FLAG_C = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT0,
        S_INIT1,
        S_MOVK,
        S_ADDK,
        S_OUT,
        S_DONE
    } fib_state_t;

    // Map a term index onto its register selector
    function automatic logic [3:0] reg_sel(input int idx);
        case (idx)
            0: return R0;    1: return R1;    2: return R2;    3: return R3;
            4: return R4;    5: return R5;    6: return R6;    7: return R7;
            8: return R8;    9: return R9;    10: return R10;  11: return R11;
            12: return R12;  13: return R13;  14: return R14;  15: return R15;
            default: return R0;
        endcase
    endfunction

    function automatic logic [15:0] enc_movi(input logic [3:0] rd, input logic [7:0] imm);
        return {OPC_MOVI, rd, imm};
    endfunction

    function automatic logic [15:0] enc_reg(input logic [3:0] rd, input logic [3:0] alu_op,
                                            input logic [3:0] rs);
        return {CLS_REGISTER, rd, alu_op, rs};
    endfunction

endpackage

// File: rtl/fib_sequencer.sv
// rtl/fib_sequencer.sv - drives an external decoder to compute Fibonacci term n; FIB_SEQ_OVF_EN enables carry saturation
module fib_sequencer
    import fib_sequencer_pkg::*;
#(
    parameter int N_MAX = 15,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] n_terms,
    input  logic [7:0]       seed0,
    input  logic [7:0]       seed1,
    input  logic [15:0]      alu_bus,
    input  logic [4:0]       flags,
    output logic [15:0]      instr,
    output logic             busy,
    output logic             done,
    output logic [15:0]      result,
    output logic             overflow
);

    fib_state_t       state, state_nxt;
    logic [CNT_W-1:0] n_q, k_q;
    logic [7:0]       seed0_q, seed1_q;
    logic [15:0]      result_q;
    logic             carry_hit;
    logic             sat;
    logic             last_term;
    logic [3:0]       rk, rk1, rk2, rn;
    logic             unused_flags;

    assign unused_flags = ^flags;
    assign last_term    = (k_q == n_q);
    assign rk           = reg_sel(int'(k_q));
    assign rk1          = reg_sel(int'(k_q) - 1);
    assign rk2          = reg_sel(int'(k_q) - 2);
    assign rn           = reg_sel(int'(n_q));

`ifdef FIB_SEQ_OVF_EN
    logic ovf_q;
    assign carry_hit = flags[FLAG_C];

    // Sticky carry flag for the current run, cleared when a new run is accepted
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else if (state == S_IDLE && start) begin
            ovf_q <= 1'b0;
        end else if (state == S_ADDK && carry_hit) begin
            ovf_q <= 1'b1;
        end
    end

    assign sat = ovf_q;
`else
    assign carry_hit = 1'b0;
    assign sat       = 1'b0;
`endif

    assign overflow = sat;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Run parameters, term counter and result capture
    always_ff @(posedge clk) begin
        if (reset) begin
            n_q      <= '0;
            k_q      <= '0;
            seed0_q  <= '0;
            seed1_q  <= '0;
            result_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        n_q     <= (int'(n_terms) > N_MAX) ? CNT_W'(N_MAX) : n_terms;
                        seed0_q <= seed0;
                        seed1_q <= seed1;
                        k_q     <= '0;
                    end
                end
                S_INIT1: k_q <= CNT_W'(2);
                S_ADDK: begin
                    if (!carry_hit && !last_term) begin
                        k_q <= k_q + 1'b1;
                    end
                end
                S_OUT: result_q <= sat ? 16'hFFFF : alu_bus;
                default: ;
            endcase
        end
    end

    // Next state and instruction issue; a saturated run spends its OUT slot on a NOP
    // so the latency stays 2k+2 without touching the decoder again
    always_comb begin
        state_nxt = state;
        instr     = INSTR_NOP;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_INIT0;
                end
            end
            S_INIT0: begin
                instr     = enc_movi(R0, seed0_q);
                state_nxt = S_INIT1;
            end
            S_INIT1: begin
                instr     = enc_movi(R1, seed1_q);
                state_nxt = (int'(n_q) < 2) ? S_OUT : S_MOVK;
            end
            S_MOVK: begin
                instr     = enc_reg(rk, ALU_MOV, rk2);
                state_nxt = S_ADDK;
            end
            S_ADDK: begin
                instr     = enc_reg(rk, ALU_ADD, rk1);
                state_nxt = (carry_hit || last_term) ? S_OUT : S_MOVK;
            end
            S_OUT: begin
                instr     = sat ? INSTR_NOP : enc_reg(rn, ALU_MOV, rn);
                state_nxt = S_DONE;
            end
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy   = (state != S_IDLE);
    assign done   = (state == S_DONE);
    assign result = result_q;

endmodule

// File: tb/tb_fib_sequencer.sv
// tb/tb_fib_sequencer.sv - randomized self-checking bench for fib_sequencer with a decoder stand-in
module tb_fib_sequencer;
    import fib_sequencer_pkg::*;

    localparam int CNT_W = 5;
    localparam int N_MAX = 15;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [CNT_W-1:0] n_terms;
    logic [7:0]       seed0, seed1;
    logic [15:0]      alu_bus;
    logic [4:0]       flags;
    logic [15:0]      instr;
    logic             busy, done, overflow;
    logic [15:0]      result;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fib_sequencer #(.N_MAX(N_MAX), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .start(start), .n_terms(n_terms),
        .seed0(seed0), .seed1(seed1), .alu_bus(alu_bus), .flags(flags),
        .instr(instr), .busy(busy), .done(done), .result(result), .overflow(overflow)
    );

    // Decoder stand-in: combinational ALU result, register write on the clock edge
    logic [15:0] regs [16];
    logic        wr_en;
    logic [3:0]  wr_rd;
    logic [16:0] sum;

    always_comb begin
        alu_bus = 16'h0000;
        flags   = 5'h00;
        wr_en   = 1'b0;
        wr_rd   = instr[11:8];
        sum     = '0;
        if (instr[15:12] == OPC_MOVI) begin
            alu_bus = {8'h00, instr[7:0]};
            wr_en   = 1'b1;
        end else if (instr[15:12] == CLS_REGISTER) begin
            wr_en = 1'b1;
            if (instr[7:4] == ALU_ADD) begin
                sum           = {1'b0, regs[instr[11:8]]} + {1'b0, regs[instr[3:0]]};
                alu_bus       = sum[15:0];
                flags[FLAG_C] = sum[16];
            end else begin
                alu_bus = regs[instr[3:0]];
            end
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) regs[i] <= 16'($urandom);
        end else if (wr_en) begin
            regs[wr_rd] <= alu_bus;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: Fibonacci recurrence on plain integers, cycle count from term index
    task automatic model(input int nt, input int s0, input int s1,
                         output int res, output int ovf, output int cyc);
        int n;
        int t[16];
        int s;
        n    = (nt > N_MAX) ? N_MAX : nt;
        t[0] = s0;
        t[1] = s1;
        ovf  = 0;
        cyc  = 2 * ((n < 1) ? 1 : n) + 2;
        for (int k = 2; k <= n; k++) begin
            s = t[k-2] + t[k-1];
`ifdef FIB_SEQ_OVF_EN
            if (s > 65535) begin
                res = 65535;
                ovf = 1;
                cyc = 2 * k + 2;
                return;
            end
`endif
            t[k] = s % 65536;
        end
        res = t[n];
    endtask

    // One run; poke > 0 pulses start in that cycle, poke < 0 picks a random busy cycle
    task automatic run(input int nt, input int s0, input int s1, input int poke);
        int          er, eo, ec, pk;
        int          done_cyc;
        int          ndone;
        logic [15:0] res_at, instr_at;
        logic        ov_at, busy_at;
        done_cyc = 0;
        ndone    = 0;
        res_at   = '0;
        instr_at = '1;
        ov_at    = 1'b0;
        busy_at  = 1'b0;
        model(nt, s0, s1, er, eo, ec);
        pk = (poke < 0) ? int'($urandom_range(1, ec)) : poke;
        @(negedge clk);
        start   = 1'b1;
        n_terms = CNT_W'(nt);
        seed0   = s0[7:0];
        seed1   = s1[7:0];
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            start   = (cyc == pk);
            n_terms = CNT_W'($urandom);
            seed0   = 8'($urandom);
            seed1   = 8'($urandom);
            if (done) begin
                ndone++;
                if (done_cyc == 0) begin
                    done_cyc = cyc;
                    res_at   = result;
                    ov_at    = overflow;
                    instr_at = instr;
                    busy_at  = busy;
                end
            end
            if (done_cyc != 0 && cyc == done_cyc + 1) check("busy_after_done", busy, 0);
            if (done_cyc != 0 && cyc == done_cyc + 3) break;
        end
        start = 1'b0;
        check("done_cycle", done_cyc, ec);
        check("done_pulses", ndone, 1);
        check("result", res_at, er);
        check("overflow", ov_at, eo);
        check("instr_in_done", instr_at, 0);
        check("busy_in_done", busy_at, 1);
    endtask

    // Reset during cycle 6 of an n=10 run must abort silently
    task automatic reset_mid_run();
        int nd;
        nd = 0;
        @(negedge clk);
        start   = 1'b1;
        n_terms = CNT_W'(10);
        seed0   = 8'd0;
        seed1   = 8'd1;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) nd++;
            if (cyc == 6) reset = 1'b1;
            if (cyc == 7) begin
                check("abort_busy", busy, 0);
                check("abort_instr", instr, 0);
                check("abort_result", result, 0);
                check("abort_overflow", overflow, 0);
                reset = 1'b0;
            end
        end
        check("abort_no_done", nd, 0);
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        n_terms = '0;
        seed0   = 8'd0;
        seed1   = 8'd0;
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_instr", instr, 0);
        check("reset_result", result, 0);
        check("reset_overflow", overflow, 0);
        reset = 1'b0;

        run(10, 0, 1, 0);
        run(20, 0, 1, 0);
        run(0, 3, 7, 0);
        run(1, 3, 7, 0);
        run(15, 255, 255, 0);
        reset_mid_run();
        run(10, 0, 1, 0);
        run(10, 0, 1, 5);
        for (int i = 0; i < 25; i++) begin
            run(int'($urandom_range(0, 31)), int'($urandom_range(0, 255)),
                int'($urandom_range(0, 255)), ($urandom_range(0, 1) == 1) ? -1 : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
